sfi_sandbox_checker: RTL and testbench

- Streaming checker on the consumer side of the SFI sandboxing rewriter.
- Receives 64-bit instruction/address words over a valid/ready stream and decodes opcode field [31:26].
- Verifies that every memory-class word carries the sandbox tag in [63:56], and forwards words through one registered stage.
- Counts violations and latches the first offending word; optionally halts the stream until software clears the fault.

---
 rtl/sfi_pkg.sv | 41 ++++
 rtl/sfi_opclass.sv | 21 ++
 rtl/sfi_sandbox_checker.sv | 94 +++++++++
 tb/tb_sfi_sandbox_checker.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sfi_pkg.sv
// Shared definitions for the SFI rewriter and checker: opcode fields, tag field, state.
// Latency: n/a (package only).
// Backpressure: n/a.
package sfi_pkg;

  // Memory-class opcodes (instruction word bits [31:26])
  localparam logic [5:0] OP_LB  = 6'd40;
  localparam logic [5:0] OP_LH  = 6'd41;
  localparam logic [5:0] OP_LWL = 6'd42;
  localparam logic [5:0] OP_LW  = 6'd43;
  localparam logic [5:0] OP_LBU = 6'd44;
  localparam logic [5:0] OP_LHU = 6'd45;
  localparam logic [5:0] OP_LWR = 6'd46;
  localparam logic [5:0] OP_SC  = 6'd56;
  localparam logic [5:0] OP_LDC = 6'd60;
  localparam logic [5:0] OP_SDC = 6'd63;

  // Field positions inside the 64-bit word
  localparam int OPC_LSB = 26;
  localparam int OPC_W   = 6;
  localparam int TAG_MSB = 63;
  localparam int TAG_LSB = 56;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } sfi_state_t;

  // True when the opcode touches memory and therefore must carry the sandbox tag
  function automatic logic is_mem_op(input logic [5:0] op);
    logic hit;
    hit = 1'b0;
    case (op)
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU,
      OP_LWR, OP_SC, OP_LDC, OP_SDC: hit = 1'b1;
      default:                       hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/sfi_opclass.sv
// Classifies a word: memory-class opcode and whether its tag matches the sandbox tag.
// Latency: purely combinational.
// Backpressure: none (no handshake).
module sfi_opclass
  import sfi_pkg::*;
#(
  parameter logic [7:0] SANDBOX_TAG = 8'hA2
) (
  input  logic [63:0] word,
  output logic        is_mem,
  output logic        tag_ok
);

  // Bits outside the opcode and tag fields do not affect classification
  logic unused_bits;
  assign unused_bits = ^{word[TAG_LSB-1:OPC_LSB+OPC_W], word[OPC_LSB-1:0]};

  assign is_mem = is_mem_op(word[OPC_LSB +: OPC_W]);
  assign tag_ok = (word[TAG_MSB:TAG_LSB] == SANDBOX_TAG);

endmodule

// File: rtl/sfi_sandbox_checker.sv
// Checks memory-class words for the sandbox tag and forwards them through one register stage.
// Latency: 1 cycle accept-to-output, full throughput, no skid buffer.
// Backpressure: in_ready follows out_ready; stalls entirely in FAULT when HALT_ON_FAULT=1.
module sfi_sandbox_checker
  import sfi_pkg::*;
#(
  parameter logic [7:0] SANDBOX_TAG   = 8'hA2,
  parameter int         CNT_W         = 16,
  parameter bit         HALT_ON_FAULT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [63:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_viol,
  output logic             fault,
  output logic [63:0]      fault_word,
  output logic [CNT_W-1:0] viol_count,
  input  logic             fault_clr
);

  sfi_state_t state;
  logic       is_mem;
  logic       tag_ok;
  logic       viol;
  logic       accept;
  logic       viol_acc;

  sfi_opclass #(
    .SANDBOX_TAG (SANDBOX_TAG)
  ) u_opclass (
    .word   (in_data),
    .is_mem (is_mem),
    .tag_ok (tag_ok)
  );

  assign viol     = is_mem && !tag_ok;
  assign in_ready = ((state == RUN) || !HALT_ON_FAULT) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign viol_acc = accept && viol;

  // Single output stage: load on accept, empty on drain, hold while stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_viol  <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_viol  <= viol;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Fault FSM; a violation accepted together with a clear starts a fresh fault
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      fault      <= 1'b0;
      fault_word <= '0;
    end else if (fault_clr) begin
      if (viol_acc) begin
        state      <= FAULT;
        fault      <= 1'b1;
        fault_word <= in_data;
      end else begin
        state <= RUN;
        fault <= 1'b0;
      end
    end else if (viol_acc && (state == RUN)) begin
      state      <= FAULT;
      fault      <= 1'b1;
      fault_word <= in_data;
    end
  end

  // Saturating violation counter; a clear restarts it, counting a coincident violation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      viol_count <= '0;
    end else if (fault_clr) begin
      viol_count <= viol_acc ? CNT_W'(1) : '0;
    end else if (viol_acc && (viol_count != '1)) begin
      viol_count <= viol_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sfi_sandbox_checker.sv
// Scoreboard bench for sfi_sandbox_checker: halting/16-bit instance and non-halting/2-bit instance.
// Latency: expects forwarded words exactly one cycle after accept.
// Backpressure: drives out_ready stalls and checks in_ready each cycle.
module tb_sfi_sandbox_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic [63:0] in_data;
  logic        in_valid;
  logic        out_ready;
  logic        fault_clr;

  logic        a_in_ready, a_out_valid, a_out_viol, a_fault;
  logic [63:0] a_out_data, a_fault_word;
  logic [15:0] a_viol_count;
  logic        b_in_ready, b_out_valid, b_out_viol, b_fault;
  logic [63:0] b_out_data, b_fault_word;
  logic [1:0]  b_viol_count;

  logic        in_ready_m, out_valid_m, out_viol_m, fault_m;
  logic [63:0] out_data_m, fault_word_m;
  logic [15:0] viol_count_m;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic        m_ov;
  logic        m_st;
  logic        m_fault;
  logic [63:0] m_fw;
  logic [15:0] m_cnt;
  logic [64:0] sbq[$];

  always #5 clk = ~clk;

  sfi_sandbox_checker #(.SANDBOX_TAG(8'hA2), .CNT_W(16), .HALT_ON_FAULT(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid && !sel),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_viol(a_out_viol), .fault(a_fault),
    .fault_word(a_fault_word), .viol_count(a_viol_count), .fault_clr(fault_clr && !sel)
  );

  sfi_sandbox_checker #(.SANDBOX_TAG(8'hA2), .CNT_W(2), .HALT_ON_FAULT(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid && sel),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_viol(b_out_viol), .fault(b_fault),
    .fault_word(b_fault_word), .viol_count(b_viol_count), .fault_clr(fault_clr && sel)
  );

  assign in_ready_m   = sel ? b_in_ready   : a_in_ready;
  assign out_valid_m  = sel ? b_out_valid  : a_out_valid;
  assign out_viol_m   = sel ? b_out_viol   : a_out_viol;
  assign fault_m      = sel ? b_fault      : a_fault;
  assign out_data_m   = sel ? b_out_data   : a_out_data;
  assign fault_word_m = sel ? b_fault_word : a_fault_word;
  assign viol_count_m = sel ? {14'd0, b_viol_count} : a_viol_count;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_viol(input logic [63:0] w);
    logic [5:0] op;
    logic       mem;
    op  = w[31:26];
    mem = (op == 6'd40) || (op == 6'd41) || (op == 6'd42) || (op == 6'd43) ||
          (op == 6'd44) || (op == 6'd45) || (op == 6'd46) || (op == 6'd56) ||
          (op == 6'd60) || (op == 6'd63);
    return mem && (w[63:56] != 8'hA2);
  endfunction

  task automatic model_reset();
    m_ov = 1'b0; m_st = 1'b0; m_fault = 1'b0; m_fw = '0; m_cnt = '0;
    sbq.delete();
  endtask

  task automatic do_reset();
    in_valid = 1'b0; fault_clr = 1'b0; out_ready = 1'b1; in_data = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("rst_out_data", out_data_m, 64'd0);
    chk("rst_out_viol", {63'd0, out_viol_m}, 64'd0);
  endtask

  // One clock cycle: drive, check against model, update scoreboard and model, advance
  task automatic cyc(input logic v, input logic [63:0] d, input logic ordy, input logic clr);
    logic        halt;
    logic [15:0] cmax;
    logic        rdy;
    logic        acc;
    logic        vi;
    logic [64:0] e;
    halt = !sel;
    cmax = sel ? 16'd3 : 16'hFFFF;
    in_valid = v; in_data = d; out_ready = ordy; fault_clr = clr;
    #1;
    rdy = (!m_st || !halt) && (!m_ov || ordy);
    chk("in_ready",   {63'd0, in_ready_m},  {63'd0, rdy});
    chk("out_valid",  {63'd0, out_valid_m}, {63'd0, m_ov});
    chk("fault",      {63'd0, fault_m},     {63'd0, m_fault});
    chk("fault_word", fault_word_m, m_fw);
    chk("viol_count", {48'd0, viol_count_m}, {48'd0, m_cnt});
    if (m_ov && ordy) begin
      if (sbq.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("out_data", out_data_m, e[63:0]);
        chk("out_viol", {63'd0, out_viol_m}, {63'd0, e[64]});
      end
    end
    acc = v && rdy;
    vi  = acc && exp_viol(d);
    if (acc) sbq.push_back({exp_viol(d), d});
    if (clr) begin
      m_cnt   = vi ? 16'd1 : 16'd0;
      m_fault = vi;
      m_st    = vi;
      if (vi) m_fw = d;
    end else if (vi) begin
      if (m_cnt != cmax) m_cnt = m_cnt + 16'd1;
      if (!m_st) begin
        m_st = 1'b1; m_fault = 1'b1; m_fw = d;
      end
    end
    if (acc) m_ov = 1'b1;
    else if (ordy) m_ov = 1'b0;
    @(negedge clk);
  endtask

  localparam logic [63:0] W_GOOD = 64'hA200_0000_A000_0000;
  localparam logic [63:0] W_BAD  = 64'h1200_0000_A000_0000;
  localparam logic [63:0] W_NMEM = 64'h1200_0000_0000_0000;

  initial begin
    logic [63:0] w;
    logic [5:0]  ops[6];
    ops[0] = 6'd40; ops[1] = 6'd56; ops[2] = 6'd63; ops[3] = 6'd0; ops[4] = 6'd47; ops[5] = 6'd60;
    sel = 1'b0;
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1; fault_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // ---- halting instance ----
    do_reset();
    cyc(1'b1, W_GOOD, 1'b1, 1'b0);
    chk("lat_valid", {63'd0, out_valid_m}, 64'd1);
    chk("lat_data", out_data_m, W_GOOD);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // violation halts the stream until cleared
    cyc(1'b1, W_BAD, 1'b1, 1'b0);
    chk("bad_viol", {63'd0, out_viol_m}, 64'd1);
    chk("bad_fault", {63'd0, fault_m}, 64'd1);
    chk("bad_fw", fault_word_m, W_BAD);
    for (int i = 0; i < 4; i++) cyc(1'b1, W_GOOD, 1'b1, 1'b0);
    chk("halt_ready", {63'd0, in_ready_m}, 64'd0);
    cyc(1'b0, '0, 1'b1, 1'b1);
    chk("clr_fault", {63'd0, fault_m}, 64'd0);
    chk("clr_cnt", {48'd0, viol_count_m}, 64'd0);
    chk("clr_fw_kept", fault_word_m, W_BAD);
    cyc(1'b1, W_GOOD, 1'b1, 1'b0);

    // non-memory word with a bad tag passes untouched
    cyc(1'b1, W_NMEM, 1'b1, 1'b0);
    chk("nmem_viol", {63'd0, out_viol_m}, 64'd0);
    chk("nmem_data", out_data_m, W_NMEM);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // backpressure: 5 stalled cycles then back-to-back drain
    cyc(1'b1, W_GOOD | 64'h1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, W_GOOD | 64'h2, 1'b0, 1'b0);
      chk("stall_data", out_data_m, W_GOOD | 64'h1);
    end
    for (int i = 2; i < 8; i++) cyc(1'b1, W_GOOD | 64'(i), 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // random traffic; clears only on idle input cycles
    for (int i = 0; i < 300; i++) begin
      w = {$urandom, $urandom};
      w[31:26] = ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) != 0) w[63:56] = 8'hA2;
      if ($urandom_range(0, 9) == 0) cyc(1'b0, w, 1'($urandom_range(0, 1)), 1'b1);
      else cyc(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 2) != 0), 1'b0);
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("a_sb_empty", 64'(sbq.size()), 64'd0);

    // ---- non-halting, 2-bit counter instance ----
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, W_BAD | 64'(i), 1'b1, 1'b0);
      if (i > 0) chk("nh_viol", {63'd0, out_viol_m}, 64'd1);
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("sat_cnt", {48'd0, viol_count_m}, 64'd3);
    chk("sat_fw", fault_word_m, W_BAD);

    // clear coincident with a violating accept re-faults on the new word
    cyc(1'b1, W_BAD | 64'hFF, 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("coinc_cnt", {48'd0, viol_count_m}, 64'd1);
    chk("coinc_fault", {63'd0, fault_m}, 64'd1);
    chk("coinc_fw", fault_word_m, W_BAD | 64'hFF);

    // reset while a word is held in the stage
    cyc(1'b1, W_GOOD, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    do_reset();
    chk("mid_rst_valid", {63'd0, out_valid_m}, 64'd0);
    chk("mid_rst_fault", {63'd0, fault_m}, 64'd0);
    chk("mid_rst_cnt", {48'd0, viol_count_m}, 64'd0);
    chk("mid_rst_fw", fault_word_m, 64'd0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b1, W_NMEM, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("b_sb_empty", 64'(sbq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
